// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LAT_W      = 3;

    // An access is rejected when it is not word aligned or falls past the
    // last word; aw is log2 of the array depth in words.
    function automatic logic addr_err(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [WORD_BYTES-1:0] be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0]           mem_q [DEPTH_WORDS];
    logic [31:0]           rdata_q;
    logic [WORD_BYTES-1:0] lane_we;

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane_we
        assign lane_we[gi] = we_i & be_i[gi];
    end

    // No reset here: contents must survive a reset of the surrounding logic.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (lane_we[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: captures one request, waits LATENCY cycles,
// performs the access on the word array and holds the response until taken.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [31:0]           req_addr_i,
    input  logic [WORD_BYTES-1:0] req_be_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [WORD_BYTES-1:0] be_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic                  rd_ok_q;

    logic                  accept;
    logic                  access;
    logic                  access_err;
    logic [31:0]           arr_rdata;

    assign accept     = (state_q == IDLE) && req_valid_i;
    assign access_err = addr_err(addr_q, AW);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_wr_i;
                addr_q  <= req_addr_i;
                be_q    <= req_be_i;
                wdata_q <= req_wdata_i;
            end
            if (access) begin
                err_q   <= access_err;
                rd_ok_q <= !wr_q && !access_err;
            end
        end
    end

    // Array strobes derive from the reset state register, so a write still
    // waiting in WAIT is dropped the moment reset is asserted.
    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (access && wr_q && !access_err),
        .re_i    (access && !wr_q && !access_err),
        .addr_i  (addr_q[AW+1:2]),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign resp_err_o   = (state_q == RESP) && err_q;
    assign resp_rdata_o = ((state_q == RESP) && rd_ok_q) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_wr, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_wr, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_mem   [256];
    bit          mdl_known [256];

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_wr_i(a_req_wr),
        .req_addr_i(a_req_addr), .req_be_i(a_req_be), .req_wdata_i(a_req_wdata),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err), .busy_o(a_busy)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wr_i(b_req_wr),
        .req_addr_i(b_req_addr), .req_be_i(b_req_be), .req_wdata_i(b_req_wdata),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .busy_o(b_busy)
    );

    // Reference: a byte-addressed word memory with alignment and range rules.
    task automatic mdl_access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] exp_rd,
                              output bit exp_err, output bit exp_known);
        int unsigned idx;
        idx       = addr / 4;
        exp_err   = (addr % 4 != 0) || (addr / 4 >= 256);
        exp_rd    = 32'd0;
        exp_known = 1'b1;
        if (exp_err) return;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl_mem[idx][8*i +: 8] = wd[8*i +: 8];
            if (be == 4'hF) mdl_known[idx] = 1'b1;
        end else begin
            exp_rd    = mdl_mem[idx];
            exp_known = mdl_known[idx];
        end
    endtask

    // Drives one request on DUT A and returns what came back; lat = edges from
    // accept to resp_valid visible, -1 on timeout.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er,
                       output int lat);
        int n;
        rd = 32'd0; er = 1'b0; lat = -1;
        a_req_wr = wr; a_req_addr = addr; a_req_be = be; a_req_wdata = wd; a_req_valid = 1'b1;
        n = 0;
        while (!a_req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!a_req_ready) begin a_req_valid = 1'b0; return; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_wr = 1'($urandom); a_req_addr = $urandom; a_req_be = 4'($urandom); a_req_wdata = $urandom;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_resp_valid && n < 20);
        if (!a_resp_valid) return;
        rd = a_resp_rdata; er = a_resp_err; lat = n;
        if (a_resp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", a_resp_valid); end
        checks++; if (a_resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_resp_rdata: got %h expected 0", a_resp_rdata); end
        checks++; if (a_resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err: got %b expected 0", a_resp_err); end
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b%b expected 00", a_busy, b_busy); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; bit er, eer, ek; int lat;
        txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
        mdl_access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, erd, eer, ek);
        $display("txn wr addr=00000010 rd=%h err=%b lat=%0d", rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if (er !== eer || rd !== erd) begin failures++; $display("FAIL wr_resp: got %h/%b expected %h/%b", rd, er, erd, eer); end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        mdl_access(1'b0, 32'h10, 4'h0, 32'h0, erd, eer, ek);
        $display("txn rd addr=00000010 rd=%h err=%b lat=%0d", rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++; if (er !== eer || rd !== erd) begin failures++; $display("FAIL rd_resp: got %h/%b expected %h/%b", rd, er, erd, eer); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd, erd; bit er, eer, ek; int lat;
        txn(1'b1, 32'h10, 4'b0101, 32'h11223344, rd, er, lat);
        mdl_access(1'b1, 32'h10, 4'b0101, 32'h11223344, erd, eer, ek);
        $display("txn wr addr=00000010 be=0101 rd=%h err=%b lat=%0d", rd, er, lat);
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        mdl_access(1'b0, 32'h10, 4'h0, 32'h0, erd, eer, ek);
        $display("txn rd addr=00000010 rd=%h err=%b lat=%0d", rd, er, lat);
        checks++; if (rd !== erd || er !== eer) begin failures++; $display("FAIL byte_enable_read: got %h/%b expected %h/%b", rd, er, erd, eer); end
        checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL byte_enable_value: got %h expected de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; bit er, eer, ek; int lat;
        logic [31:0] addrs [6] = '{32'h0, 32'h13, 32'h400, 32'h0, 32'h3FC, 32'h3FC};
        bit          wrs   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] wds   [6] = '{32'h01234567, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h89ABCDEF, 32'h0};
        for (int i = 0; i < 6; i++) begin
            txn(wrs[i], addrs[i], 4'hF, wds[i], rd, er, lat);
            mdl_access(wrs[i], addrs[i], 4'hF, wds[i], erd, eer, ek);
            $display("txn %s addr=%h rd=%h err=%b lat=%0d", wrs[i] ? "wr" : "rd", addrs[i], rd, er, lat);
            checks++; if (er !== eer) begin failures++; $display("FAIL err_flag[%0d]: got %b expected %b", i, er, eer); end
            checks++; if (rd !== erd) begin failures++; $display("FAIL err_rdata[%0d]: got %h expected %h", i, rd, erd); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd; bit er, eer, ek, wr; int lat, r; logic [3:0] be;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            txn(1'b1, 32'h100 + 4*i, 4'hF, wd, rd, er, lat);
            mdl_access(1'b1, 32'h100 + 4*i, 4'hF, wd, erd, eer, ek);
        end
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            wr = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            if (r < 8)       addr = 32'h100 + 4 * $urandom_range(0, 15);
            else if (r == 8) addr = (32'h100 + $urandom_range(0, 63)) | 32'h1;
            else begin
                addr = $urandom & 32'hFFFF_FFFC;
                if (addr < 32'h400) addr = addr | 32'h400;
            end
            txn(wr, addr, be, wd, rd, er, lat);
            mdl_access(wr, addr, be, wd, erd, eer, ek);
            $display("txn %s addr=%h be=%b rd=%h err=%b lat=%0d", wr ? "wr" : "rd", addr, be, rd, er, lat);
            checks++; if (lat !== 3) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 3", i, lat); end
            checks++; if (er !== eer) begin failures++; $display("FAIL rand_err[%0d]: got %b expected %b", i, er, eer); end
            if (ek) begin
                checks++; if (rd !== erd) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rd, erd); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] erd; bit eer, ek; int n;
        a_resp_ready = 1'b0;
        a_req_wr = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0; a_req_wdata = 32'h0; a_req_valid = 1'b1;
        @(posedge clk); #1;
        mdl_access(1'b0, 32'h10, 4'h0, 32'h0, erd, eer, ek);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_resp_valid && n < 20);
        $display("txn rd addr=00000010 backpressured rd=%h err=%b lat=%0d", a_resp_rdata, a_resp_err, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL bp_latency: got %0d expected 3", n); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== erd || a_resp_err !== eer || a_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b expected v=1 d=%h e=%b rdy=0",
                         k, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, erd, eer);
            end
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL bp_release: got v=%b rdy=%b busy=%b expected 0 1 0", a_resp_valid, a_req_ready, a_busy); end
        @(posedge clk); #1;
        checks++; if (a_busy !== 1'b1 || a_req_ready !== 1'b0) begin failures++; $display("FAIL bp_accept: got busy=%b rdy=%b expected 1 0", a_busy, a_req_ready); end
        a_req_valid = 1'b0;
        mdl_access(1'b0, 32'h10, 4'h0, 32'h0, erd, eer, ek);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_resp_valid && n < 20);
        $display("txn rd addr=00000010 after backpressure rd=%h err=%b lat=%0d", a_resp_rdata, a_resp_err, n);
        checks++; if (n !== 3 || a_resp_rdata !== erd) begin failures++; $display("FAIL bp_second: got lat=%0d d=%h expected lat=3 d=%h", n, a_resp_rdata, erd); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, erd; bit er, eer, ek; int lat;
        txn(1'b1, 32'h20, 4'hF, 32'h00000005, rd, er, lat);
        mdl_access(1'b1, 32'h20, 4'hF, 32'h00000005, erd, eer, ek);
        a_req_wr = 1'b1; a_req_addr = 32'h20; a_req_be = 4'hF; a_req_wdata = 32'hCAFEF00D; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL midrst_in_wait: got busy=%b expected 1", a_busy); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        $display("txn reset during write: rdy=%b v=%b d=%h e=%b busy=%b", a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err, a_busy);
        checks++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'd0 || a_resp_err !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs: got rdy=%b v=%b d=%h e=%b busy=%b expected 1 0 0 0 0",
                     a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err, a_busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        mdl_access(1'b0, 32'h20, 4'h0, 32'h0, erd, eer, ek);
        $display("txn rd addr=00000020 rd=%h err=%b lat=%0d", rd, er, lat);
        checks++; if (rd !== erd || lat !== 3) begin failures++; $display("FAIL midrst_preserved: got %h lat=%0d expected %h lat=3", rd, lat, erd); end
    endtask

    task automatic test_back_to_back();
        bit exp_q [$];
        bit e;
        int last = -1, acc = 0, idle = 0, r;
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        b_req_addr   = 32'h40;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (b_resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL stream_extra_resp: got response at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn stream resp cyc=%0d err=%b rd=%h", cyc, b_resp_err, b_resp_rdata);
                    checks++; if (b_resp_err !== e) begin failures++; $display("FAIL stream_err: got %b expected %b", b_resp_err, e); end
                    if (e) begin
                        checks++; if (b_resp_rdata !== 32'd0) begin failures++; $display("FAIL stream_err_rdata: got %h expected 0", b_resp_rdata); end
                    end
                end
            end
            if (!b_busy) idle++;
            if (b_req_ready) begin
                if (last >= 0) begin
                    checks++; if (cyc - last !== 3) begin failures++; $display("FAIL stream_spacing: got %0d expected 3", cyc - last); end
                end
                last = cyc;
                acc++;
                exp_q.push_back((b_req_addr % 4 != 0) || (b_req_addr / 4 >= 256));
            end
            @(posedge clk); #1;
            r = int'($urandom_range(0, 7));
            if (r < 5)       b_req_addr = 4 * $urandom_range(0, 255);
            else if (r == 5) b_req_addr = 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
            else             b_req_addr = 32'h400 + 4 * $urandom_range(0, 4095);
        end
        b_req_valid = 1'b0;
        checks++; if (acc !== 15) begin failures++; $display("FAIL stream_accepts: got %0d expected 15", acc); end
        checks++; if (idle !== acc) begin failures++; $display("FAIL stream_idle_cycles: got %0d expected %0d", idle, acc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = 32'h0; a_req_be = 4'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 32'h0; b_req_be = 4'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
